// File: rtl/enemy_draw.sv
// Enemy formation renderer: ROWS x COLS sprite grid placed at a latched origin,
// with per-enemy alive mask. Define ENEMY_FRAME_LATCH_EN to latch the origin at vblank rise.
module enemy_draw #(
   parameter int          SPRITE_W  = 32,
   parameter int          SPRITE_H  = 32,
   parameter int          COLS      = 5,
   parameter int          ROWS      = 2,
   parameter int          SPACING_X = 64,
   parameter int          SPACING_Y = 48,
   parameter logic [11:0] TRANSP    = 12'h000,
   localparam int         AW        = $clog2(SPRITE_W * SPRITE_H),
   localparam int         N         = ROWS * COLS
) (
   input  logic          pclk,
   input  logic          rst,
   input  logic [10:0]   x_pos,
   input  logic [10:0]   y_pos,
   input  logic          level_start,
   input  logic          kill_valid,
   input  logic [3:0]    kill_idx,
   input  logic [10:0]   hcount_in,
   input  logic [10:0]   vcount_in,
   input  logic          hsync_in,
   input  logic          vsync_in,
   input  logic          hblnk_in,
   input  logic          vblnk_in,
   input  logic [11:0]   rgb_in,
   input  logic [11:0]   rgb_pixel,
   output logic [AW-1:0] pixel_addr,
   output logic [10:0]   hcount_out,
   output logic [10:0]   vcount_out,
   output logic          hsync_out,
   output logic          vsync_out,
   output logic          hblnk_out,
   output logic          vblnk_out,
   output logic [11:0]   rgb_out,
   output logic [N-1:0]  alive,
   output logic          all_dead
);

   localparam int XB = $clog2(SPRITE_W);
   localparam int YB = $clog2(SPRITE_H);

   logic [10:0]   x_lat_q, x_lat_d, y_lat_q, y_lat_d;
   logic [N-1:0]  alive_q, alive_d;
   logic          all_dead_q, all_dead_d;
   logic          hit1_q, hit1_d;
   logic [AW-1:0] pixel_addr_q, pixel_addr_d;
   logic [25:0]   tim1_q, tim1_d, tim2_q, tim2_d;
   logic [11:0]   rgb1_q, rgb1_d, rgb_out_q, rgb_out_d;
   logic [11:0]   h12, v12;
`ifdef ENEMY_FRAME_LATCH_EN
   logic          vblnk_prev_q, vblnk_prev_d;
`endif

   assign h12 = {1'b0, hcount_in};
   assign v12 = {1'b0, vcount_in};

   always_comb begin
`ifdef ENEMY_FRAME_LATCH_EN
      vblnk_prev_d = vblnk_in;
      if (vblnk_in && !vblnk_prev_q) begin
         x_lat_d = x_pos;
         y_lat_d = y_pos;
      end else begin
         x_lat_d = x_lat_q;
         y_lat_d = y_lat_q;
      end
`else
      x_lat_d = x_pos;
      y_lat_d = y_pos;
`endif

      alive_d = alive_q;
      if (level_start) begin
         alive_d = {N{1'b1}};
      end else if (kill_valid && ({1'b0, kill_idx} < 5'(N))) begin
         alive_d[kill_idx] = 1'b0;
      end else begin
         alive_d = alive_q;
      end
      all_dead_d = (alive_d == {N{1'b0}});

      // Spacing >= sprite size guarantees at most one enemy covers a pixel.
      hit1_d       = 1'b0;
      pixel_addr_d = {AW{1'b0}};
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            logic [11:0] ox, oy, dx, dy;
            ox = {1'b0, x_lat_q} + 12'(c * SPACING_X);
            oy = {1'b0, y_lat_q} + 12'(r * SPACING_Y);
            dx = h12 - ox;
            dy = v12 - oy;
            if (h12 >= ox && h12 < ox + 12'(SPRITE_W) &&
                v12 >= oy && v12 < oy + 12'(SPRITE_H) &&
                alive_q[r*COLS+c] && !hblnk_in && !vblnk_in) begin
               hit1_d       = 1'b1;
               pixel_addr_d = {dy[YB-1:0], dx[XB-1:0]};
            end else begin
               hit1_d       = hit1_d;
            end
         end
      end

      tim1_d    = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in};
      rgb1_d    = rgb_in;
      tim2_d    = tim1_q;
      rgb_out_d = (hit1_q && rgb_pixel != TRANSP) ? rgb_pixel : rgb1_q;
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         x_lat_q      <= 11'd0;
         y_lat_q      <= 11'd0;
         alive_q      <= {N{1'b1}};
         all_dead_q   <= 1'b0;
         hit1_q       <= 1'b0;
         pixel_addr_q <= {AW{1'b0}};
         tim1_q       <= 26'd0;
         rgb1_q       <= 12'd0;
         tim2_q       <= 26'd0;
         rgb_out_q    <= 12'd0;
`ifdef ENEMY_FRAME_LATCH_EN
         vblnk_prev_q <= 1'b0;
`endif
      end else begin
         x_lat_q      <= x_lat_d;
         y_lat_q      <= y_lat_d;
         alive_q      <= alive_d;
         all_dead_q   <= all_dead_d;
         hit1_q       <= hit1_d;
         pixel_addr_q <= pixel_addr_d;
         tim1_q       <= tim1_d;
         rgb1_q       <= rgb1_d;
         tim2_q       <= tim2_d;
         rgb_out_q    <= rgb_out_d;
`ifdef ENEMY_FRAME_LATCH_EN
         vblnk_prev_q <= vblnk_prev_d;
`endif
      end
   end

   assign pixel_addr = pixel_addr_q;
   assign {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} = tim2_q;
   assign rgb_out    = rgb_out_q;
   assign alive      = alive_q;
   assign all_dead   = all_dead_q;

endmodule

// File: tb/tb_enemy_draw.sv
// Randomized bench for enemy_draw against a geometric reference model; honours ENEMY_FRAME_LATCH_EN.
module tb_enemy_draw;

   localparam int SW = 32, SH = 32, NC = 5, NR = 2, PX = 64, PY = 48, NE = 10;

   typedef struct packed {
      logic        hit;
      logic [9:0]  addr;
      logic [11:0] rgb;
      logic [25:0] tim;
   } ent_t;

   logic        pclk = 1'b0;
   logic        rst = 1'b1;
   logic [10:0] x_pos = 11'd0, y_pos = 11'd0;
   logic        level_start = 1'b0, kill_valid = 1'b0;
   logic [3:0]  kill_idx = 4'd0;
   logic [10:0] hcount_in = 11'd0, vcount_in = 11'd0;
   logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
   logic [11:0] rgb_in = 12'd0, rgb_pixel = 12'd0;
   logic [9:0]  pixel_addr;
   logic [10:0] hcount_out, vcount_out;
   logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
   logic [11:0] rgb_out;
   logic [9:0]  alive;
   logic        all_dead;

   int   errs = 0, checks = 0;
   int   rom_mode = 0;
   int   m_x = 0, m_y = 0;
   logic m_vprev = 1'b0;
   logic [9:0] m_alive = 10'h3FF;
   ent_t p = '0;

   enemy_draw dut (
      .pclk(pclk), .rst(rst), .x_pos(x_pos), .y_pos(y_pos),
      .level_start(level_start), .kill_valid(kill_valid), .kill_idx(kill_idx),
      .hcount_in(hcount_in), .vcount_in(vcount_in), .hsync_in(hsync_in),
      .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
      .rgb_in(rgb_in), .rgb_pixel(rgb_pixel), .pixel_addr(pixel_addr),
      .hcount_out(hcount_out), .vcount_out(vcount_out), .hsync_out(hsync_out),
      .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
      .rgb_out(rgb_out), .alive(alive), .all_dead(all_dead)
   );

   always #5 pclk = ~pclk;

   function automatic logic [11:0] rom_f(input logic [9:0] a);
      if (rom_mode == 0) return 12'hF00;
      if (a % 7 == 0) return 12'h000;
      return 12'(a * 37 + 5) | 12'h001;
   endfunction

   // Sprite ROM: registered read, data ready before the next rising edge.
   always @(negedge pclk) rgb_pixel <= rom_f(pixel_addr);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step(input int h, input int v, input logic hb, input logic vb, input logic [11:0] rgb);
      ent_t cur;
      logic hs, vs;
      logic [11:0] exp_rgb, rv;
      hs = 1'($urandom_range(0, 1));
      vs = 1'($urandom_range(0, 1));
      hcount_in = 11'(h); vcount_in = 11'(v);
      hsync_in = hs; vsync_in = vs; hblnk_in = hb; vblnk_in = vb; rgb_in = rgb;
      cur = '0;
      if (!hb && !vb) begin
         for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++) begin
               int ox, oy;
               ox = m_x + c * PX;
               oy = m_y + r * PY;
               if (h >= ox && h < ox + SW && v >= oy && v < oy + SH && m_alive[r*NC+c]) begin
                  cur.hit  = 1'b1;
                  cur.addr = 10'((v - oy) * SW + (h - ox));
               end
            end
      end
      cur.rgb = rgb;
      cur.tim = {11'(h), 11'(v), hs, vs, hb, vb};
      if (rst) begin
         cur = '0; p = '0; m_alive = 10'h3FF; m_x = 0; m_y = 0; m_vprev = 1'b0;
      end else begin
`ifdef ENEMY_FRAME_LATCH_EN
         if (vb && !m_vprev) begin m_x = int'(x_pos); m_y = int'(y_pos); end
         m_vprev = vb;
`else
         m_x = int'(x_pos); m_y = int'(y_pos);
`endif
         if (level_start) m_alive = 10'h3FF;
         else if (kill_valid && kill_idx < 4'd10) m_alive[kill_idx] = 1'b0;
      end
      @(posedge pclk);
      #1;
      rv = rom_f(p.addr);
      exp_rgb = (p.hit && rv != 12'h000) ? rv : p.rgb;
      chk("pixel_addr", 32'(pixel_addr), 32'(cur.addr));
      chk("rgb_out", 32'(rgb_out), 32'(exp_rgb));
      chk("timing", 32'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}), 32'(p.tim));
      chk("alive", 32'(alive), 32'(m_alive));
      chk("all_dead", 32'(all_dead), 32'(m_alive == 10'd0));
      p = cur;
      kill_valid = 1'b0;
      level_start = 1'b0;
   endtask

   task automatic vblank(input int n);
      for (int i = 0; i < n; i++) step(0, 600, 1'b0, 1'b1, 12'h000);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(900, 10, 1'b1, 1'b0, 12'h0A0);
   endtask

   initial begin
      rst = 1'b1;
      step(5, 5, 1'b0, 1'b0, 12'h123);
      step(7, 9, 1'b0, 1'b0, 12'h456);
      rst = 1'b0;
      x_pos = 11'd100; y_pos = 11'd100;
      idle(2);
      vblank(3);
      idle(2);
      chk("alive_reset", 32'(alive), 32'h3FF);

      step(100, 100, 1'b0, 1'b0, 12'h00F);
      step(132, 100, 1'b0, 1'b0, 12'h00F);
      chk("tp_f00", 32'(rgb_out), 32'hF00);
      step(164, 100, 1'b0, 1'b0, 12'h00F);
      chk("tp_gap", 32'(rgb_out), 32'h00F);
      step(101, 101, 1'b0, 1'b0, 12'h00F);
      chk("tp_col2", 32'(rgb_out), 32'hF00);
      chk("tp_addr33", 32'(pixel_addr), 32'd33);

      rom_mode = 1;
      idle(2);
      step(100, 100, 1'b0, 1'b0, 12'h0F0);
      idle(1);
      chk("tp_transp", 32'(rgb_out), 32'h0F0);

      kill_valid = 1'b1; kill_idx = 4'd1;
      idle(1);
      chk("tp_kill1", 32'(alive), 32'h3FD);
      for (int h = 160; h < 200; h++) step(h, 100, 1'b0, 1'b0, 12'($urandom));
      kill_valid = 1'b1; kill_idx = 4'd12;
      idle(1);
      chk("tp_kill_oor", 32'(alive), 32'h3FD);

      for (int i = 0; i < NE; i++) begin
         kill_valid = 1'b1; kill_idx = 4'(i);
         idle(1);
      end
      chk("tp_all_dead", 32'(all_dead), 32'd1);
      level_start = 1'b1;
      idle(1);
      chk("tp_revive", 32'(alive), 32'h3FF);
      level_start = 1'b1; kill_valid = 1'b1; kill_idx = 4'd0;
      idle(1);
      chk("tp_lvl_wins", 32'(alive), 32'h3FF);

      // Origin moves mid-frame; the model decides when the image follows.
      for (int h = 95; h < 160; h++) begin
         if (h == 110) x_pos = 11'd120;
         step(h, 110, 1'b0, 1'b0, 12'($urandom));
      end
      vblank(2);
      for (int h = 95; h < 160; h++) step(h, 110, 1'b0, 1'b0, 12'($urandom));

      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 19) == 0) begin kill_valid = 1'b1; kill_idx = 4'($urandom_range(0, 15)); end
         if ($urandom_range(0, 59) == 0) level_start = 1'b1;
         if ($urandom_range(0, 99) == 0) begin
            x_pos = 11'($urandom_range(40, 300)); y_pos = 11'($urandom_range(40, 200));
         end
         if ($urandom_range(0, 79) == 0) vblank(2);
         step($urandom_range(30, 460), $urandom_range(30, 260),
              1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 15) == 0), 12'($urandom));
      end

      level_start = 1'b1;
      x_pos = 11'd2040; y_pos = 11'd100;
      idle(1);
      vblank(2);
      for (int h = 0; h < 40; h++) step(h, 110, 1'b0, 1'b0, 12'($urandom));
      for (int h = 2030; h < 2048; h++) step(h, 110, 1'b0, 1'b0, 12'($urandom));

      step(2045, 110, 1'b0, 1'b0, 12'h777);
      rst = 1'b1;
      step(2046, 110, 1'b0, 1'b0, 12'h777);
      chk("rst_rgb", 32'(rgb_out), 32'h000);
      chk("rst_addr", 32'(pixel_addr), 32'h000);
      rst = 1'b0;
      for (int h = 100; h < 140; h++) step(h, 5, 1'b0, 1'b0, 12'($urandom));

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/enemy_draw.md
# enemy_draw

Renders the enemy formation into the VGA pixel stream. Consumes the per-level trajectory position (x_pos/y_pos) produced by the enemy position generator and places a ROWS×COLS grid of enemy sprites relative to it. Tracks which enemies are alive and removes killed enemies from the image. Sits in the VGA draw chain after the background/player stage; addresses a shared synchronous sprite ROM.

## Interface
Parameters:
- SPRITE_W, 32: sprite width in pixels (power of 2).
- SPRITE_H, 32: sprite height in pixels (power of 2).
- COLS, 5: enemies per row.
- ROWS, 2: rows in the formation; ROWS*COLS ≤ 16.
- SPACING_X, 64: horizontal pitch between enemy origins; must be ≥ SPRITE_W.
- SPACING_Y, 48: vertical pitch between enemy origins; must be ≥ SPRITE_H.
- TRANSP, 12'h000: sprite colour treated as transparent.

Ports:
- pclk  in  1  pixel clock.
- rst  in  1  reset, synchronous, active-high.
- x_pos  in  11  formation origin x from the position generator.
- y_pos  in  11  formation origin y from the position generator.
- level_start  in  1  one-cycle pulse; revives all enemies.
- kill_valid  in  1  one-cycle kill request.
- kill_idx  in  4  enemy index, row*COLS+col.
- hcount_in, vcount_in  in  11 each  pixel position.
- hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  timing.
- rgb_in  in  12  upstream colour.
- rgb_pixel  in  12  sprite ROM data, valid one cycle after pixel_addr.
- pixel_addr  out  log2(SPRITE_W*SPRITE_H)  sprite ROM address, {row_in_sprite, col_in_sprite}.
- hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out  out  timing delayed 2 cycles.
- rgb_out  out  12  composed colour.
- alive  out  ROWS*COLS  per-enemy alive mask.
- all_dead  out  1  high when alive == 0.

## Operation
- Position latch: x_lat/y_lat load x_pos/y_pos on the cycle vblnk_in rises (vblnk_in=1, previous vblnk_in=0). All geometry in a frame uses x_lat/y_lat.
- Geometry: enemy (r,c) occupies hcount in [x_lat+c*SPACING_X, +SPRITE_W), vcount in [y_lat+r*SPACING_Y, +SPRITE_H). All sums computed at 12 bits; no wrap, so off-screen origins draw nothing.
- Stage 1: find the covering enemy (at most one due to spacing constraint); hit1 = covered && alive[idx] && !hblnk_in && !vblnk_in. pixel_addr = {vcount−oy, hcount−ox} (low bits). When no hit, pixel_addr = 0.
- Stage 2: rgb_out = (hit2 && rgb_pixel != TRANSP) ? rgb_pixel : rgb_in delayed 2.
- Alive register: level_start → all ones. Else kill_valid with kill_idx < ROWS*COLS → clear that bit; out-of-range or already-dead index ignored. level_start and kill_valid in the same cycle: level_start wins, kill lost.
- all_dead registered from the next-state alive mask (same cycle as alive update).

## Timing
- Reset values: alive = all ones, all_dead = 0, x_lat = y_lat = 0, pixel_addr = 0, rgb_out = 0, all timing outputs 0.
- Pixel path latency: exactly 2 pclk for all timing outputs and rgb_out.
- pixel_addr registered, 1 cycle after inputs; ROM data consumed next cycle.
- Kill/level_start: alive and all_dead reflect the change one cycle after the pulse; effect on image from the next pixel entering stage 1.
- Mid-frame kill: enemy disappears partway down its sprite; accepted.
- Reset mid-frame: pipeline cleared; output 0 for 2 cycles then resumes.

## Configuration
- ENEMY_FRAME_LATCH_EN defined: position latched at vblank rise as above.
- Not defined: x_lat/y_lat load x_pos/y_pos every cycle (live tracking; tearing possible). All else unchanged.

## Test plan
- Reset then idle frame, x_pos=100, y_pos=100, ROM constant 12'hF00, rgb_in=12'h00F -> pixel (100,100) gives rgb_out=F00 two cycles later, pixel (132,100) gives 00F, pixel (164,100) gives F00, alive=10'h3FF.
- ROM returns TRANSP at address 0 -> pixel (100,100) passes rgb_in; pixel_addr at (101,101) equals 33.
- kill_valid with kill_idx=1 -> alive=10'h3FD next cycle; pixels (164..195,100) pass rgb_in; kill_idx=12 -> alive unchanged.
- Kill all ten indices -> all_dead=1 in the cycle after the last kill; level_start -> alive=10'h3FF, all_dead=0; same-cycle level_start+kill_idx=0 -> alive=10'h3FF.
- x_pos changes 100->120 mid-frame (macro defined) -> image unchanged until after next vblnk_in rise, then origin at 120; macro undefined -> origin moves immediately.
- x_pos=2040 -> no sprite pixels on screen, no wrap into column 0; assert rst mid-line -> all outputs 0 next cycle.
